// File: rtl/mtimer_pkg.sv
// Register offsets, reset values, bus types and address decode for the mtimer
// RISC-V machine timer peripheral.
package mtimer_pkg;

    localparam logic [31:0] MTIMER_MTIME_LO_OFFSET    = 32'h00;
    localparam logic [31:0] MTIMER_MTIME_HI_OFFSET    = 32'h04;
    localparam logic [31:0] MTIMER_MTIMECMP_LO_OFFSET = 32'h08;
    localparam logic [31:0] MTIMER_MTIMECMP_HI_OFFSET = 32'h0C;
    localparam logic [31:0] MTIMER_CTRL_OFFSET        = 32'h10;
    localparam logic [31:0] MTIMER_PRESCALE_OFFSET    = 32'h14;
    localparam logic [31:0] MTIMER_ADDR_LIMIT         = 32'h18;

    localparam logic [63:0] MTIMER_MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic        MTIMER_EN_RST       = 1'b0;
    localparam logic [15:0] MTIMER_PRESCALE_RST = 16'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } mtimer_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } mtimer_reg_rsp_t;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_CTRL,
        REG_PRESCALE,
        REG_NONE
    } mtimer_reg_e;

    function automatic mtimer_reg_e mtimer_decode(input logic [31:0] addr);
        mtimer_reg_e sel;
        sel = REG_NONE;
        if (addr[1:0] == 2'b00 && addr < MTIMER_ADDR_LIMIT) begin
            case (addr)
                MTIMER_MTIME_LO_OFFSET:    sel = REG_MTIME_LO;
                MTIMER_MTIME_HI_OFFSET:    sel = REG_MTIME_HI;
                MTIMER_MTIMECMP_LO_OFFSET: sel = REG_CMP_LO;
                MTIMER_MTIMECMP_HI_OFFSET: sel = REG_CMP_HI;
                MTIMER_CTRL_OFFSET:        sel = REG_CTRL;
                MTIMER_PRESCALE_OFFSET:    sel = REG_PRESCALE;
                default:                   sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mtimer.sv
// 64-bit machine timer (mtime/mtimecmp) with prescaler, coherent-read shadow
// and a registered level interrupt, on a single-cycle register bus slot.
module mtimer
    import mtimer_pkg::*;
#(
    parameter type reg_req_t = mtimer_reg_req_t,
    parameter type reg_rsp_t = mtimer_reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output logic     time_irq_o
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;
    logic [31:0] r_shadow;
    logic        r_irq;

    mtimer_reg_e w_sel;
    logic        w_wr;
    logic        w_rd_lo;
    logic        w_tick;
    logic        w_pcnt_clr;
    logic [31:0] w_wmask;
    logic [31:0] w_old;
    logic [31:0] w_wval;
    logic [31:0] w_rdata;

    assign w_sel      = mtimer_decode(reg_req_i.addr);
    assign w_wr       = reg_req_i.valid && reg_req_i.write && (w_sel != REG_NONE);
    assign w_rd_lo    = reg_req_i.valid && !reg_req_i.write && (w_sel == REG_MTIME_LO);
    assign w_tick     = r_en && (r_pcnt == r_prescale);
    assign w_pcnt_clr = w_wr && (w_sel == REG_CTRL || w_sel == REG_PRESCALE);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wmask
            assign w_wmask[gi*8 +: 8] = {8{reg_req_i.wstrb[gi]}};
        end
    endgenerate

    // w_old is the live register contents a partial write merges into; for
    // MTIME_HI that is the counter itself, not the shadow that reads return.
    always_comb begin
        w_old = 32'h0;
        case (w_sel)
            REG_MTIME_LO: w_old = r_mtime[31:0];
            REG_MTIME_HI: w_old = r_mtime[63:32];
            REG_CMP_LO:   w_old = r_mtimecmp[31:0];
            REG_CMP_HI:   w_old = r_mtimecmp[63:32];
            REG_CTRL:     w_old = {31'h0, r_en};
            REG_PRESCALE: w_old = {16'h0, r_prescale};
            default:      w_old = 32'h0;
        endcase
    end

    assign w_wval = (w_old & ~w_wmask) | (reg_req_i.wdata & w_wmask);

    always_comb begin
        w_rdata = 32'h0;
        if (reg_req_i.valid) begin
            w_rdata = (w_sel == REG_MTIME_HI) ? r_shadow : w_old;
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = w_rdata;
        reg_rsp_o.error = reg_req_i.valid && (w_sel == REG_NONE);
        reg_rsp_o.ready = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime    <= MTIMER_MTIME_RST;
            r_mtimecmp <= MTIMER_MTIMECMP_RST;
            r_en       <= MTIMER_EN_RST;
            r_prescale <= MTIMER_PRESCALE_RST;
            r_pcnt     <= 16'h0;
            r_shadow   <= 32'h0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);

            if (w_rd_lo) begin
                r_shadow <= r_mtime[63:32];
            end

            if (w_pcnt_clr || w_tick) begin
                r_pcnt <= 16'h0;
            end else if (r_en) begin
                r_pcnt <= r_pcnt + 16'd1;
            end

            // A bus write to either mtime half swallows a coincident increment.
            if (w_wr && w_sel == REG_MTIME_LO) begin
                r_mtime <= {r_mtime[63:32], w_wval};
            end else if (w_wr && w_sel == REG_MTIME_HI) begin
                r_mtime <= {w_wval, r_mtime[31:0]};
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr && w_sel == REG_CMP_LO) begin
                r_mtimecmp[31:0] <= w_wval;
            end
            if (w_wr && w_sel == REG_CMP_HI) begin
                r_mtimecmp[63:32] <= w_wval;
            end
            if (w_wr && w_sel == REG_CTRL) begin
                r_en <= w_wval[0];
            end
            if (w_wr && w_sel == REG_PRESCALE) begin
                r_prescale <= w_wval[15:0];
            end
        end
    end

    assign time_irq_o = r_irq;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: reset/decode vector table, hand-written timing
// sequences, and randomized bus traffic against a cycle-count reference model.
module tb_mtimer;
    import mtimer_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    mtimer_reg_req_t req;
    mtimer_reg_rsp_t rsp;
    logic            irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mtimer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .reg_req_i  (req),
        .reg_rsp_o  (rsp),
        .time_irq_o (irq)
    );

    // Reference model: mtime advances once every (PRESCALE+1) enabled cycles,
    // counted from the last CTRL/PRESCALE write.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [15:0] m_pre;
    logic [31:0] m_shadow;
    logic        m_irq;
    int          m_k;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h18);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (!addr_bad(a)) begin
            case (a)
                32'h00: v = m_mtime[31:0];
                32'h04: v = m_shadow;
                32'h08: v = m_cmp[31:0];
                32'h0C: v = m_cmp[63:32];
                32'h10: v = {31'h0, m_en};
                32'h14: v = {16'h0, m_pre};
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [63:0] nt;
        logic [63:0] ncmp;
        logic        nen;
        logic [15:0] npre;
        logic [31:0] w;
        int          nk;
        if (rst) begin
            m_mtime  <= 64'h0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_en     <= 1'b0;
            m_pre    <= 16'h0;
            m_shadow <= 32'h0;
            m_irq    <= 1'b0;
            m_k      <= 0;
        end else begin
            nt   = m_mtime;
            ncmp = m_cmp;
            nen  = m_en;
            npre = m_pre;
            nk   = m_en ? m_k + 1 : m_k;
            if (m_en && ((m_k + 1) % (int'(m_pre) + 1) == 0)) nt = m_mtime + 64'd1;
            if (req.valid && !req.write && req.addr == 32'h0) m_shadow <= m_mtime[63:32];
            if (req.valid && req.write && !addr_bad(req.addr)) begin
                w = merge(model_rd(req.addr), req.wdata, req.wstrb);
                case (req.addr)
                    32'h00: nt = {m_mtime[63:32], merge(m_mtime[31:0], req.wdata, req.wstrb)};
                    32'h04: nt = {merge(m_mtime[63:32], req.wdata, req.wstrb), m_mtime[31:0]};
                    32'h08: ncmp[31:0]  = w;
                    32'h0C: ncmp[63:32] = w;
                    32'h10: begin nen = w[0]; nk = 0; end
                    32'h14: begin npre = w[15:0]; nk = 0; end
                    default: ;
                endcase
            end
            m_irq   <= (m_mtime >= m_cmp);
            m_mtime <= nt;
            m_cmp   <= ncmp;
            m_en    <= nen;
            m_pre   <= npre;
            m_k     <= nk;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic er,
                          output logic rdy, output logic iq);
        @(negedge clk);
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = a;
        req.wdata = wd;
        req.wstrb = st;
        #1;
        rd  = rsp.rdata;
        er  = rsp.error;
        rdy = rsp.ready;
        iq  = irq;
        $display("txn %s addr=%h wdata=%h wstrb=%b rdata=%h err=%b irq=%b",
                 wr ? "WR" : "RD", a, wd, st, rd, er, iq);
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic er, rdy, iq;
        access(1'b1, a, wd, 4'hF, rd, er, rdy, iq);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic er, rdy, iq;
        access(1'b0, a, 32'h0, 4'h0, rd, er, rdy, iq);
        chk(name, {32'h0, rd}, {32'h0, exp});
        chk({name, "_err"}, {63'h0, er}, 64'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    function automatic vec_t vr(input logic [31:0] a, input logic [31:0] e, input logic er);
        vec_t v;
        v = '{1'b0, a, 32'h0, 4'h0, e, er};
        return v;
    endfunction

    function automatic vec_t vw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        vec_t v;
        v = '{1'b1, a, d, s, 32'h0, 1'b0};
        return v;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t        vt[28];
        logic [31:0] rd;
        logic        er, rdy, iq;
        logic [31:0] addrs[8];

        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_irq", {63'h0, irq}, 64'h0);

        // Reset values, decode errors, ignored writes and byte-strobe merges.
        vt[0]  = vr(32'h00, 32'h0, 1'b0);
        vt[1]  = vr(32'h04, 32'h0, 1'b0);
        vt[2]  = vr(32'h08, 32'hFFFF_FFFF, 1'b0);
        vt[3]  = vr(32'h0C, 32'hFFFF_FFFF, 1'b0);
        vt[4]  = vr(32'h10, 32'h0, 1'b0);
        vt[5]  = vr(32'h14, 32'h0, 1'b0);
        vt[6]  = vr(32'h18, 32'h0, 1'b1);
        vt[7]  = vr(32'h02, 32'h0, 1'b1);
        vt[8]  = vr(32'h40, 32'h0, 1'b1);
        vt[9]  = vw(32'h18, 32'hFFFF_FFFF, 4'hF);
        vt[10] = vw(32'h16, 32'h0000_1234, 4'hF);
        vt[11] = vw(32'h11, 32'h0000_0001, 4'hF);
        vt[12] = vr(32'h14, 32'h0, 1'b0);
        vt[13] = vr(32'h10, 32'h0, 1'b0);
        vt[14] = vw(32'h14, 32'h0000_ABCD, 4'b0010);
        vt[15] = vr(32'h14, 32'h0000_AB00, 1'b0);
        vt[16] = vw(32'h08, 32'h1122_3344, 4'b0101);
        vt[17] = vr(32'h08, 32'hFF22_FF44, 1'b0);
        vt[18] = vr(32'h0C, 32'hFFFF_FFFF, 1'b0);
        vt[19] = vw(32'h10, 32'hFFFF_FFFE, 4'hF);
        vt[20] = vr(32'h10, 32'h0, 1'b0);
        vt[21] = vw(32'h04, 32'hDEAD_BEEF, 4'b1000);
        vt[22] = vr(32'h04, 32'h0, 1'b0);
        vt[23] = vr(32'h00, 32'h0, 1'b0);
        vt[24] = vr(32'h04, 32'hDE00_0000, 1'b0);
        vt[25] = vw(32'h00, 32'h1234_5678, 4'b0011);
        vt[26] = vr(32'h00, 32'h0000_5678, 1'b0);
        vt[27] = vr(32'h04, 32'hDE00_0000, 1'b0);
        for (int i = 0; i < 28; i++) begin
            access(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, rdy, iq);
            chk($sformatf("tbl%0d_ready", i), {63'h0, rdy}, 64'h1);
            chk($sformatf("tbl%0d_irq", i), {63'h0, iq}, 64'h0);
            if (!vt[i].wr) begin
                chk($sformatf("tbl%0d_rdata", i), {32'h0, rd}, {32'h0, vt[i].exp_rd});
                chk($sformatf("tbl%0d_err", i), {63'h0, er}, {63'h0, vt[i].exp_err});
            end
        end

        // Prescaler: PRESCALE=3 for 40 cycles gives mtime=10; rewriting
        // PRESCALE mid-count restarts the 4-cycle period.
        do_reset();
        wr_reg(32'h14, 32'd3);
        wr_reg(32'h10, 32'd1);
        idle(40);
        rd_chk("pre40_lo", 32'h00, 32'd10);
        rd_chk("pre40_hi", 32'h04, 32'd0);
        wr_reg(32'h14, 32'd3);
        for (int k = 0; k < 5; k++) rd_chk($sformatf("prewr_%0d", k), 32'h00, (k == 4) ? 32'd11 : 32'd10);

        // Interrupt rises one cycle after mtime reaches mtimecmp, falls one
        // cycle after mtimecmp is raised.
        do_reset();
        wr_reg(32'h0C, 32'd0);
        wr_reg(32'h08, 32'd20);
        wr_reg(32'h10, 32'd1);
        for (int j = 1; j <= 22; j++) begin
            idle(1);
            chk($sformatf("irq_rise_%0d", j), {63'h0, irq}, (j >= 21) ? 64'h1 : 64'h0);
        end
        wr_reg(32'h08, 32'd1000);
        chk("irq_hold", {63'h0, irq}, 64'h1);
        idle(1);
        chk("irq_fall", {63'h0, irq}, 64'h0);

        // Carry into the high word and shadow coherence across a late HI read.
        do_reset();
        wr_reg(32'h00, 32'hFFFF_FFFE);
        wr_reg(32'h10, 32'd1);
        idle(2);
        rd_chk("carry_lo", 32'h00, 32'h0);
        idle(5);
        rd_chk("carry_hi", 32'h04, 32'h1);

        // Bus write to MTIME_LO beats the increment due in the same cycle.
        do_reset();
        wr_reg(32'h10, 32'd1);
        idle(3);
        wr_reg(32'h00, 32'h55);
        rd_chk("coll_lo0", 32'h00, 32'h55);
        idle(4);
        rd_chk("coll_lo5", 32'h00, 32'h5A);
        rd_chk("coll_hi", 32'h04, 32'h0);

        // Wrap from all-ones to zero, with the interrupt tracking mtime==mtimecmp.
        do_reset();
        wr_reg(32'h00, 32'hFFFF_FFFF);
        wr_reg(32'h04, 32'hFFFF_FFFF);
        wr_reg(32'h10, 32'd1);
        chk("wrap_irq_on", {63'h0, irq}, 64'h1);
        rd_chk("wrap_lo_ones", 32'h00, 32'hFFFF_FFFF);
        rd_chk("wrap_lo_zero", 32'h00, 32'h0);
        chk("wrap_irq_off", {63'h0, irq}, 64'h0);
        rd_chk("wrap_hi_zero", 32'h04, 32'h0);

        // Asynchronous reset drops the interrupt without waiting for a clock edge.
        do_reset();
        wr_reg(32'h0C, 32'd0);
        wr_reg(32'h08, 32'd0);
        idle(1);
        chk("arst_irq_pre", {63'h0, irq}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_irq_drop", {63'h0, irq}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("arst_cmp_lo", 32'h08, 32'hFFFF_FFFF);

        // Randomized traffic against the reference model.
        do_reset();
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h0};
        for (int n = 0; n < 400; n++) begin
            int          slot;
            logic        w;
            logic [31:0] a, d, exp_rd;
            logic [3:0]  s;
            logic        exp_er, exp_iq;
            idle($urandom_range(0, 2));
            slot = $urandom_range(0, 7);
            a    = addrs[slot];
            if (slot == 7) a = {$urandom_range(0, 7), 2'b00} | 32'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            case (slot)
                5:       d = $urandom_range(0, 4);
                4:       d = $urandom;
                default: d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300) : $urandom;
            endcase
            s      = 4'($urandom_range(0, 15));
            exp_rd = model_rd(a);
            exp_er = addr_bad(a);
            exp_iq = m_irq;
            access(w, a, d, s, rd, er, rdy, iq);
            chk($sformatf("rnd%0d_irq", n), {63'h0, iq}, {63'h0, exp_iq});
            if (!w) begin
                chk($sformatf("rnd%0d_rdata_a%0h", n, a), {32'h0, rd}, {32'h0, exp_rd});
                chk($sformatf("rnd%0d_err", n), {63'h0, er}, {63'h0, exp_er});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
